// File: rtl/div_32_seq_if.sv
// Handshake and data bundle between the multdiv pipeline latch and the sequential divider.
interface div_32_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_DIV,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_remainder,
        input  data_exception,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  ctrl_DIV,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_remainder,
        output data_exception,
        output data_resultRDY,
        output busy
    );
endinterface

// File: rtl/div_32_seq.sv
// Multicycle signed restoring divider: one quotient bit per clock, sign fix-up in a final cycle.
module div_32_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clock,
    input logic         reset,
    div_32_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             dbz_q;
    logic             ovf_q;

    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] remainder_q;
    logic             exception_q;
    logic             rdy_q;
    logic             busy_q;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] sub;
    logic             sub_ok;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             start_dbz;
    logic             start_ovf;

    always_comb begin
        abs_a = bus.data_operandA[WIDTH-1] ? negate(bus.data_operandA) : bus.data_operandA;
        abs_b = bus.data_operandB[WIDTH-1] ? negate(bus.data_operandB) : bus.data_operandB;
        start_dbz = (bus.data_operandB == '0);
        start_ovf = (bus.data_operandA == MinInt) && (bus.data_operandB == '1);

        // Adder path: R_shifted + ~|B| + 1; the carry out means R_shifted >= |B|.
        rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        sub       = {1'b0, rem_shift} + {1'b0, ~{1'b0, dvs_q}} + (WIDTH + 2)'(1);
        sub_ok    = sub[WIDTH+1];
        rem_step  = sub_ok ? sub[WIDTH:0] : rem_shift;
        quo_step  = {quo_q[WIDTH-2:0], sub_ok};
    end

    // Partial remainder stays below |B|, so its top bit is always clear between steps.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else if (bus.ctrl_DIV) begin
            // A start in any state discards whatever division is in flight.
            state_q   <= StRun;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= abs_a;
            dvs_q     <= abs_b;
            neg_quo_q <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            neg_rem_q <= bus.data_operandA[WIDTH-1];
            dbz_q     <= start_dbz;
            ovf_q     <= start_ovf;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            rdy_q <= 1'b0;
            unique case (state_q)
                StIdle: ;
                StRun: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    if (dbz_q) begin
                        result_q    <= '0;
                        remainder_q <= '0;
                        exception_q <= 1'b1;
                    end else if (ovf_q) begin
                        result_q    <= MinInt;
                        remainder_q <= '0;
                        exception_q <= 1'b1;
                    end else begin
                        result_q    <= neg_quo_q ? negate(quo_q) : quo_q;
                        remainder_q <= neg_rem_q ? negate(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
                        exception_q <= 1'b0;
                    end
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_remainder = remainder_q;
    assign bus.data_exception = exception_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_div_32_seq.sv
// Directed bench for div_32_seq: latency, signs, exceptions, abort, reset and back-to-back starts.
module tb_div_32_seq;
    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic saw_rdy;

    div_32_seq_if #(.WIDTH(32)) bus ();

    div_32_seq #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_DIV = 1'b0;
    endtask

    task automatic wait_rdy(input string tag);
        int k = 0;
        while (bus.data_resultRDY !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
        check({tag, " latency"}, 32'(k), 32'd33);
    endtask

    task automatic check_out(input string tag, input logic [31:0] q, input logic [31:0] r,
                             input logic e);
        check({tag, " result"}, bus.data_result, q);
        check({tag, " remainder"}, bus.data_remainder, r);
        check({tag, " exception"}, 32'(bus.data_exception), 32'(e));
    endtask

    task automatic check_after(input string tag);
        @(negedge clock);
        check({tag, " rdy drop"}, 32'(bus.data_resultRDY), 32'd0);
        check({tag, " busy drop"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        reset             = 1'b1;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) @(negedge clock);
        check_out("reset", 32'd0, 32'd0, 1'b0);
        check("reset rdy", 32'(bus.data_resultRDY), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        do_start(32'd100, 32'd7);
        check("100/7 busy", 32'(bus.busy), 32'd1);
        wait_rdy("100/7");
        check_out("100/7", 32'd14, 32'd2, 1'b0);
        check_after("100/7");

        do_start(32'hFFFF_FF9C, 32'd7);
        wait_rdy("-100/7");
        check_out("-100/7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        check_after("-100/7");

        do_start(32'd100, 32'hFFFF_FFF9);
        wait_rdy("100/-7");
        check_out("100/-7", 32'hFFFF_FFF2, 32'd2, 1'b0);
        check_after("100/-7");

        do_start(32'd12345, 32'd0);
        wait_rdy("dbz");
        check_out("dbz", 32'd0, 32'd0, 1'b1);
        check_after("dbz");

        do_start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_rdy("ovf");
        check_out("ovf", 32'h8000_0000, 32'd0, 1'b1);
        check_after("ovf");

        // Restart while busy: first division must never report.
        do_start(32'd1000, 32'd10);
        saw_rdy = 1'b0;
        repeat (14) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) saw_rdy = 1'b1;
        end
        check("abort no rdy", 32'(saw_rdy), 32'd0);
        do_start(32'd9, 32'd3);
        wait_rdy("restart 9/3");
        check_out("restart 9/3", 32'd3, 32'd0, 1'b0);
        check_after("restart 9/3");

        // Reset mid-operation clears everything and the division is lost.
        do_start(32'd50, 32'd5);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_out("midreset", 32'd0, 32'd0, 1'b0);
        check("midreset rdy", 32'(bus.data_resultRDY), 32'd0);
        check("midreset busy", 32'(bus.busy), 32'd0);
        reset   = 1'b0;
        saw_rdy = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) saw_rdy = 1'b1;
        end
        check("midreset no rdy", 32'(saw_rdy), 32'd0);

        do_start(32'd50, 32'd5);
        wait_rdy("50/5");
        check_out("50/5", 32'd10, 32'd0, 1'b0);

        // New start in the RDY cycle; completed outputs must hold meanwhile.
        do_start(32'h7FFF_FFFF, 32'd1);
        check_out("b2b hold", 32'd10, 32'd0, 1'b0);
        check("b2b rdy low", 32'(bus.data_resultRDY), 32'd0);
        check("b2b busy", 32'(bus.busy), 32'd1);
        wait_rdy("b2b");
        check_out("b2b", 32'h7FFF_FFFF, 32'd0, 1'b0);
        check_after("b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
